countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 16 +
 rtl/sub10.sv | 18 +
 rtl/countdown_timer.sv | 90 +++++++++
 tb/tb_countdown_timer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer block.
// The defaults here set the parameter defaults of countdown_timer.
package countdown_timer_pkg;

   localparam int CNT_W    = 9;
   localparam int DEF_STEP = 10;
   localparam int DEF_WARN = 50;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSED,
      ST_EXPIRED
   } state_t;

endpackage

// File: rtl/sub10.sv
// Saturating unsigned subtractor: d = a - b clamped at zero, borrow flags a < b.
// Purely combinational; the counter register lives in the top.
module sub10
   import countdown_timer_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] d,
   output logic         borrow
);

   assign borrow = (a < b);
   // Clamp instead of wrapping so the result never exceeds the previous count.
   assign d      = borrow ? '0 : (a - b);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, warn threshold, underflow borrow pulse and
// an expired state held until the next start.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int STEP = DEF_STEP,
   parameter int WARN = DEF_WARN
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   input  logic             pause,
   output logic [CNT_W-1:0] count,
   output logic             borrow,
   output logic             expired,
   output logic             warn
);

   localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] diff;
   logic             sub_borrow;
   logic             borrow_nxt;

   sub10 #(.W(CNT_W)) u_sub10 (
      .a      (count),
      .b      (STEP_V),
      .d      (diff),
      .borrow (sub_borrow)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         count  <= '0;
         borrow <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         borrow <= borrow_nxt;
      end
   end

   // NOTE: every output of this block is defaulted first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      borrow_nxt = 1'b0;

      if (start) begin
         // start wins over tick and pause in every state.
         count_nxt = load_val;
         state_nxt = (load_val == '0) ? ST_EXPIRED : ST_RUN;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_RUN: begin
               if (pause) begin
                  state_nxt = ST_PAUSED;
               end else if (tick) begin
                  count_nxt  = diff;
                  borrow_nxt = sub_borrow;
                  // Covers both exact hit (count == STEP) and underflow.
                  if (diff == '0) state_nxt = ST_EXPIRED;
               end
            end
            ST_PAUSED: begin
               if (!pause) state_nxt = ST_RUN;
            end
            ST_EXPIRED: count_nxt = '0;
            default: begin
               state_nxt = ST_IDLE;
               count_nxt = '0;
            end
         endcase
      end
   end

   assign expired = (state == ST_EXPIRED);
   assign warn    = ((state == ST_RUN) || (state == ST_PAUSED)) && (count <= WARN_V);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed table-driven bench for countdown_timer (STEP=10, WARN=50),
// plus hand-written sequences for asynchronous reset behaviour.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [8:0] load_val;
   logic       tick;
   logic       pause;
   logic [8:0] count;
   logic       borrow;
   logic       expired;
   logic       warn;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   countdown_timer #(.STEP(10), .WARN(50)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .load_val (load_val),
      .tick     (tick),
      .pause    (pause),
      .count    (count),
      .borrow   (borrow),
      .expired  (expired),
      .warn     (warn)
   );

   typedef struct {
      string      name;
      logic       st;
      logic [8:0] ld;
      logic       tk;
      logic       ps;
      logic [8:0] c;
      logic       b;
      logic       e;
      logic       w;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string name, input logic st, input logic [8:0] ld,
                               input logic tk, input logic ps, input logic [8:0] c,
                               input logic b, input logic e, input logic w);
      vec_t v;
      v.name = name; v.st = st; v.ld = ld; v.tk = tk; v.ps = ps;
      v.c = c; v.b = b; v.e = e; v.w = w;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [8:0] c, input logic b,
                        input logic e, input logic w);
      n_vec++;
      if (count !== c || borrow !== b || expired !== e || warn !== w) begin
         n_err++;
         $display("FAIL %s: got count=%0d borrow=%b expired=%b warn=%b, want count=%0d borrow=%b expired=%b warn=%b",
                  name, count, borrow, expired, warn, c, b, e, w);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 ns after the rising edge.
   task automatic drive(input logic st, input logic [8:0] ld, input logic tk, input logic ps);
      @(negedge clk);
      start = st; load_val = ld; tick = tk; pause = ps;
      @(posedge clk);
      #1;
      start = 1'b0; tick = 1'b0; pause = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; load_val = '0; tick = 1'b0; pause = 1'b0;

      //   name              st ld   tk ps  count b  e  w
      add("idle_ignore",     0, 0,   1, 1,  0,    0, 0, 0);
      add("s35_load",        1, 35,  0, 0,  35,   0, 0, 1);
      add("s35_t1",          0, 0,   1, 0,  25,   0, 0, 1);
      add("s35_t2",          0, 0,   1, 0,  15,   0, 0, 1);
      add("s35_t3",          0, 0,   1, 0,  5,    0, 0, 1);
      add("s35_t4_borrow",   0, 0,   1, 0,  0,    1, 1, 0);
      add("s35_borrow_gone", 0, 0,   0, 0,  0,    0, 1, 0);
      add("exp_tick_ign",    0, 0,   1, 0,  0,    0, 1, 0);
      add("s30_load",        1, 30,  0, 0,  30,   0, 0, 1);
      add("s30_t1",          0, 0,   1, 0,  20,   0, 0, 1);
      add("s30_t2",          0, 0,   1, 0,  10,   0, 0, 1);
      add("s30_t3_exact",    0, 0,   1, 0,  0,    0, 1, 0);
      add("s30_hold",        0, 0,   0, 0,  0,    0, 1, 0);
      add("s100_load",       1, 100, 0, 0,  100,  0, 0, 0);
      add("s100_t1",         0, 0,   1, 0,  90,   0, 0, 0);
      add("s100_t2",         0, 0,   1, 0,  80,   0, 0, 0);
      add("pause_tick1",     0, 0,   1, 1,  80,   0, 0, 0);
      add("pause_tick2",     0, 0,   1, 1,  80,   0, 0, 0);
      add("pause_tick3",     0, 0,   1, 1,  80,   0, 0, 0);
      add("unpause",         0, 0,   0, 0,  80,   0, 0, 0);
      add("resume_t",        0, 0,   1, 0,  70,   0, 0, 0);
      add("t_60",            0, 0,   1, 0,  60,   0, 0, 0);
      add("t_50_warn_edge",  0, 0,   1, 0,  50,   0, 0, 1);
      add("t_40",            0, 0,   1, 0,  40,   0, 0, 1);
      add("start_tick_pri",  1, 200, 1, 0,  200,  0, 0, 0);
      add("pause_200",       0, 0,   0, 1,  200,  0, 0, 0);
      add("start_in_pause",  1, 45,  0, 1,  45,   0, 0, 1);
      add("run_after_start", 0, 0,   1, 0,  35,   0, 0, 1);
      add("s0_expired",      1, 0,   0, 0,  0,    0, 1, 0);
      add("s511_load",       1, 511, 0, 0,  511,  0, 0, 0);
      add("s511_t1",         0, 0,   1, 0,  501,  0, 0, 0);

      // Reset state while reset_n is held low.
      @(posedge clk); #1;
      check("reset_state", 9'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].ld, vecs[i].tk, vecs[i].ps);
         check(vecs[i].name, vecs[i].c, vecs[i].b, vecs[i].e, vecs[i].w);
      end

      // Asynchronous reset mid-count: takes effect without a clock edge.
      drive(1'b1, 9'd130, 1'b0, 1'b0);
      check("r_load130", 9'd130, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 9'd0, 1'b1, 1'b0);
      check("r_count120", 9'd120, 1'b0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("r_async_clear", 9'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 9'd0, 1'b1, 1'b0);
      check("r_idle_tick_ign", 9'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 9'd0, 1'b1, 1'b1);
      check("r_idle_pause_ign", 9'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 9'd80, 1'b0, 1'b0);
      check("r_restart80", 9'd80, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 9'd0, 1'b1, 1'b0);
      check("r_restart_t", 9'd70, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
